// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Holds opcode/funct constants, the 4-bit FSM state encoding, ALU op codes
// and the alu_src_b / pc_src select codes.
// Optional feature macro: MIPS_CTRL_JUMP_EN (adds the JUMP state for opcode j).
package mips_ctrl_pkg;

  // Opcodes (instruction bits 31:26)
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instruction bits 5:0)
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B operand selects
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10
`ifdef MIPS_CTRL_JUMP_EN
    , S_JUMP = 4'd11
`endif
  } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the R-type funct field to an ALU operation.
// Ports:
//   funct       in  6  instruction bits 5:0
//   alu_control out 3  ALU op code (add for any unsupported funct)
//   illegal     out 1  funct is not one of add/sub/and/or/slt
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    unique case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the MIPS core: sequences the shared ALU and the
// unified instruction/data memory, holding memory states until mem_ready.
// Optional feature macro: MIPS_CTRL_JUMP_EN (decode opcode j into JUMP;
// otherwise j is reported as illegal).
// Ports:
//   clk, reset (async, active-high)
//   opcode, funct      IR fields;  zero  ALU zero flag;  mem_ready  memory done
//   mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
//   alu_control, reg_dst, mem_to_reg, reg_we   datapath controls
//   illegal_op         one-cycle pulse on unsupported opcode/funct
//   state              current FSM state (debug)
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_we,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic [2:0] funct_alu;
  logic       funct_illegal;

  // Ungated enables; reset masks them below so nothing fires while held.
  logic mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c, illegal_c;

  mips_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_control (funct_alu),
    .illegal     (funct_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    reg_we_c    = 1'b0;
    illegal_c   = 1'b0;
    iord        = 1'b0;
    pc_src      = PCSRC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REGB;
    alu_control = ALU_ADD;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_we_c   = mem_ready;
        pc_we_c   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MIPS_CTRL_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_we_c   = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        illegal_c   = funct_illegal;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we_c = 1'b1;
        reg_dst  = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = PCSRC_ALUOUT;
        pc_we_c     = zero;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_we_c = 1'b1;
        state_d  = S_FETCH;
      end
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_we_c = 1'b1;
        state_d = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  assign mem_req    = mem_req_c & ~reset;
  assign mem_we     = mem_we_c  & ~reset;
  assign ir_we      = ir_we_c   & ~reset;
  assign pc_we      = pc_we_c   & ~reset;
  assign reg_we     = reg_we_c  & ~reset;
  assign illegal_op = illegal_c & ~reset;
  assign state      = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the MIPS core. It sequences one shared ALU and one unified instruction/data memory across several cycles per instruction. It drives the multiplexer selects and write enables of the multicycle datapath, and holds each memory access until the memory signals ready. The block replaces the single-cycle combinational control unit when the core is built in multicycle form.

## Interface
Parameters: none. Encodings come from the shared package.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces FSM to FETCH
- opcode  in  6  instruction bits 31:26, taken from the datapath IR
- funct  in  6  instruction bits 5:0, taken from the datapath IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (valid only with mem_req)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  instruction register load
- pc_we  out  1  PC load (already qualified by branch and zero)
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_control  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
- reg_dst  out  1  register destination select: 0 = rt, 1 = rd
- mem_to_reg  out  1  register write-data select: 0 = ALUOut, 1 = MDR
- reg_we  out  1  register file write
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct
- state  out  4  current state, for debug

## Operation
- Outputs are decoded combinationally from the state, with gating by mem_ready and zero where noted.
- Defaults: all enables 0, alu_src_a 0, alu_src_b 00, alu_control 010, pc_src 00, reg_dst 0, mem_to_reg 0.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States, encoded 0 to 11:
  - FETCH (0): mem_req=1, iord=0, alu_src_b=01, add. ir_we=pc_we=mem_ready. Goes to DECODE on mem_ready, otherwise stays.
  - DECODE (1): alu_src_b=11, add (precomputes the branch target). Next state by opcode: lw/sw→MEMADR, R→EXEC, beq→BRANCH, addi→ADDIEX, j→JUMP. Any other opcode: illegal_op=1 and go to FETCH.
  - MEMADR (2): alu_src_a=1, alu_src_b=10, add. lw→MEMRD, sw→MEMWR.
  - MEMRD (3): mem_req=1, iord=1. Goes to MEMWB on mem_ready.
  - MEMWB (4): reg_we=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
  - MEMWR (5): mem_req=1, mem_we=1, iord=1. Goes to FETCH on mem_ready.
  - EXEC (6): alu_src_a=1, alu_src_b=00, alu_control taken from funct. Goes to ALUWB.
  - ALUWB (7): reg_we=1, reg_dst=1. Goes to FETCH.
  - BRANCH (8): alu_src_a=1, sub, pc_src=01, pc_we=zero. Goes to FETCH.
  - ADDIEX (9): alu_src_a=1, alu_src_b=10, add. Goes to ADDIWB.
  - ADDIWB (10): reg_we=1, reg_dst=0. Goes to FETCH.
  - JUMP (11): pc_src=10, pc_we=1. Goes to FETCH.
- Funct decode:
  - 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Any other funct gives 010 and illegal_op=1 in EXEC; the write-back still happens.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- opcode and funct are only sampled in DECODE and EXEC. The IR must stay stable, which holds because ir_we is asserted only in FETCH.

## Timing
- Reset:
  - Asynchronous: state becomes FETCH immediately.
  - While reset is high, mem_req, mem_we, ir_we, pc_we, reg_we and illegal_op are forced to 0.
  - The other outputs take their FETCH values.
  - The first fetch request goes out in the first cycle after reset deasserts.
- Reset in the middle of an instruction aborts it. No partial write-back occurs after the reset edge.
- Latency with zero-wait memory (mem_ready tied high), in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs hold steady while waiting.
- ir_we and pc_we in FETCH are asserted only in the mem_ready cycle.
- The PC advances once per instruction in FETCH, and at most once more in BRANCH or JUMP.

## Configuration
- MIPS_CTRL_JUMP_EN defined: opcode 000010 is decoded to the JUMP state.
- MIPS_CTRL_JUMP_EN undefined:
  - The JUMP state is not compiled.
  - j is treated as illegal (illegal_op pulse, return to FETCH).
  - pc_src never takes the value 10.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode and funct constants
  - the 4-bit state encoding
  - ALU op codes
  - the alu_src_b and pc_src select codes
- One sub-module: mips_alu_decoder, which maps funct to alu_control and an illegal flag. It is used in EXEC.

## Test plan
- R-type add (funct 100000), mem_ready=1 → states 0,1,6,7,0. alu_control=010 in EXEC; reg_we=1 and reg_dst=1 only in cycle 4.
- lw with mem_ready low for 2 cycles in MEMRD → total latency 7 cycles. iord=1 and mem_req=1 held for 3 cycles; reg_we and mem_to_reg=1 in MEMWB.
- beq, once with zero=1 and once with zero=0 → pc_we=1 with pc_src=01 in BRANCH for zero=1; pc_we=0 for zero=0. Latency 3 cycles each.
- sw → mem_we=1 only in MEMWR; reg_we never asserted; 4 cycles.
- Opcode 111111, then j with the macro defined and undefined → illegal_op pulses in DECODE for 111111. With the macro, j produces pc_src=10 and pc_we=1; without it, j pulses illegal_op.
- Reset asserted during MEMWR while waiting → state 0 asynchronously, mem_we drops at once. Fetch restarts on the first cycle after reset deasserts.
